raw2rgb_bayer_p: RTL and testbench
==================================

Name: raw2rgb_bayer_p

Overview:
- Parametrised Bayer-to-RGB converter for the D8M camera path, between raw capture (or frame-buffer readout) and the VGA/processing pipeline.
- Owns a single-line buffer and pixel/line counters.
- Performs 2x2-window demosaic with a runtime-selectable Bayer phase.
- Optional BT.601-weighted grayscale mode.
- Fixed 2-cycle latency from accepted input to output.

Parameters:
- DATA_W, 10, raw pixel width.
- OUT_W, 8, output channel width (DATA_W >= OUT_W); MSBs kept.
- LINE_MAX, 1024, max pixels per line; line buffer depth.
- ADDR_W, 10, line buffer address width; 2**ADDR_W >= LINE_MAX.

Ports:
- VGA_CLK  in  1  single clock; all logic on rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- iFVAL  in  1  frame valid.
- iLVAL  in  1  line valid.
- iDVAL  in  1  pixel strobe; pixel accepted when iFVAL&iLVAL&iDVAL.
- iDATA  in  DATA_W  raw Bayer pixel.
- iPATTERN  in  2  colour at (0,0): 0=RGGB, 1=GRBG, 2=GBRG, 3=BGGR.
- iMODE  in  1  0=colour, 1=gray on all three channels.
- oRed/oGreen/oBlue  out  OUT_W each  demosaiced channels.
- oGray  out  OUT_W  luma, always computed.
- oDVAL  out  1  output valid.
- oOVF  out  1  sticky: a line exceeded LINE_MAX in this frame.

Behaviour:
- Reset (RESET_N=0 at edge): all outputs 0, counters 0, pattern/mode latches 0, state WAIT.
- Reset mid-frame: remaining pixels of that frame are ignored.
- States:
  - WAIT -> ACTIVE on iFVAL rising edge (previous registered iFVAL=0, current=1). On that edge, latch iPATTERN/iMODE, clear oOVF, set Y=0.
  - ACTIVE -> WAIT on iFVAL falling edge.
  - In WAIT, no pixel is accepted and oDVAL=0.
- iPATTERN and iMODE changes take effect only at the next frame start.
- Counters:
  - X clears on each iLVAL rising edge and increments per accepted pixel.
  - Y increments on each iLVAL falling edge during ACTIVE.
  - Stalls (iDVAL=0 within a line) freeze X; there is no output for stalled cycles.
- Line buffer (1 x LINE_MAX x DATA_W): on accepted pixel, read address X (previous line) then write iDATA at X in the same cycle (read-before-write). Stage 1 also registers the previous pixel and the previous-line pixel at X-1.
- Window for accepted pixel (X,Y): {P(Y-1,X-1), P(Y-1,X), P(Y,X-1), P(Y,X)}.
  - The top-left parity (X-1, Y-1) combined with the latched pattern selects R and B positions; the two remaining positions are G.
  - R, B: the raw values.
  - G = (G1+G2)>>1, computed at DATA_W+1 bits; no rounding.
- Output scaling: each channel takes bits [DATA_W-1 : DATA_W-OUT_W].
- Gray: (77*R + 150*G + 29*B) >> 8 on DATA_W channels; intermediate width DATA_W+8; result scaled as above. In iMODE=1, oRed=oGreen=oBlue=oGray.
- oDVAL = 1 exactly 2 cycles after an accepted pixel with X>=1, Y>=1, X<LINE_MAX; otherwise 0.
  - Frame of W x H (W<=LINE_MAX) yields (W-1)*(H-1) valid outputs.
  - Channel outputs hold their last value when oDVAL=0.
- Overflow: an accepted pixel with X>=LINE_MAX is not written, produces no output, sets oOVF. X saturates at LINE_MAX.
- Boundaries:
  - iFVAL falling while pixels are in the pipeline: in-flight outputs still complete.
  - iLVAL rising in the same cycle as iFVAL rising: frame start is processed first; the line starts with Y=0.

Test Plan:
- RGGB, DATA_W=10, OUT_W=8, 4x2 frame; row0 = 100,200,104,204; row1 = 300,400,304,404 -> first valid output R=25, G=62, B=100; second output R=26, G=63, B=100. Exactly 3 oDVAL pulses, each 2 cycles after its input.
- Same data with iPATTERN=3 (BGGR) -> first output R=100, G=62, B=25. Changing iPATTERN mid-frame to 0 -> no effect until next iFVAL rise.
- iMODE=1, window with R=1000, G1=G2=0, B=0 -> oGray=oRed=oGreen=oBlue=75 (77000>>8=300, >>2).
- iDVAL toggling 1,0,1,0 within a line -> outputs identical to contiguous case, spaced by stalls; X unaffected by stall cycles.
- LINE_MAX=8, line of 10 pixels -> oOVF=1 after pixel 9, no oDVAL for pixels 8-9. oOVF clears at next frame start.
- RESET_N low for 1 cycle mid-line -> all outputs 0 next cycle. No oDVAL until a new iFVAL rising edge, even if iLVAL/iDVAL remain high.

Source files
------------

// File: rtl/raw2rgb_bayer_p.sv
// rtl/raw2rgb_bayer_p.sv - Bayer 2x2 demosaic with single line buffer, runtime phase select and luma output
module raw2rgb_bayer_p #(
  parameter int DATA_W   = 10,
  parameter int OUT_W    = 8,
  parameter int LINE_MAX = 1024,
  parameter int ADDR_W   = 10
) (
  input  logic              VGA_CLK,
  input  logic              RESET_N,
  input  logic              iFVAL,
  input  logic              iLVAL,
  input  logic              iDVAL,
  input  logic [DATA_W-1:0] iDATA,
  input  logic [1:0]        iPATTERN,
  input  logic              iMODE,
  output logic [OUT_W-1:0]  oRed,
  output logic [OUT_W-1:0]  oGreen,
  output logic [OUT_W-1:0]  oBlue,
  output logic [OUT_W-1:0]  oGray,
  output logic              oDVAL,
  output logic              oOVF
);
  localparam int XW = ADDR_W + 1;
  localparam int LW = DATA_W + 8;
  localparam int SH = DATA_W - OUT_W;

  typedef enum logic {S_WAIT = 1'b0, S_ACTIVE = 1'b1} state_t;
  state_t r_state, w_state_nxt;

  logic              r_fval, r_lval, r_y_odd, r_y_nz, r_mode;
  logic [1:0]        r_pat;
  logic [XW-1:0]     r_x;
  logic [DATA_W-1:0] r_line [LINE_MAX];
  logic [DATA_W-1:0] r_s1_ul, r_s1_up, r_s1_l, r_s1_c;
  logic              r_s1_xp, r_s1_yp, r_s1_vld;

  logic              w_frame_rise, w_frame_fall, w_line_rise, w_line_fall;
  logic              w_accept, w_in_range, w_write, w_y_odd, w_y_nz;
  logic [XW-1:0]     w_x;
  logic [ADDR_W-1:0] w_addr;

  assign w_frame_rise = iFVAL & ~r_fval;
  assign w_frame_fall = ~iFVAL & r_fval;
  assign w_line_rise  = iLVAL & ~r_lval;
  assign w_line_fall  = ~iLVAL & r_lval;
  // The frame-start cycle itself may carry the first pixel of line 0.
  assign w_accept   = RESET_N & iFVAL & iLVAL & iDVAL & ((r_state == S_ACTIVE) | w_frame_rise);
  assign w_x        = w_line_rise ? '0 : r_x;
  assign w_in_range = (w_x < XW'(LINE_MAX));
  assign w_write    = w_accept & w_in_range;
  assign w_addr     = w_x[ADDR_W-1:0];
  assign w_y_odd    = w_frame_rise ? 1'b0 : r_y_odd;
  assign w_y_nz     = ~w_frame_rise & r_y_nz;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_WAIT:   if (w_frame_rise) w_state_nxt = S_ACTIVE;
      S_ACTIVE: if (w_frame_fall) w_state_nxt = S_WAIT;
      default:  w_state_nxt = S_WAIT;
    endcase
  end

  // Edge detectors reset high so a frame already in progress is not mistaken for a new one.
  always_ff @(posedge VGA_CLK) begin
    if (!RESET_N) begin
      r_state <= S_WAIT;
      r_fval  <= 1'b1;
      r_lval  <= 1'b1;
      r_x     <= '0;
      r_y_odd <= 1'b0;
      r_y_nz  <= 1'b0;
      r_pat   <= 2'd0;
      r_mode  <= 1'b0;
      oOVF    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_fval  <= iFVAL;
      r_lval  <= iLVAL;
      if (w_frame_rise) begin
        r_pat   <= iPATTERN;
        r_mode  <= iMODE;
        r_y_odd <= 1'b0;
        r_y_nz  <= 1'b0;
      end else if ((r_state == S_ACTIVE) && w_line_fall) begin
        r_y_odd <= ~r_y_odd;
        r_y_nz  <= 1'b1;
      end
      if (w_accept) r_x <= w_in_range ? w_x + 1'b1 : w_x;
      else if (w_line_rise) r_x <= '0;
      if (w_accept && !w_in_range) oOVF <= 1'b1;
      else if (w_frame_rise) oOVF <= 1'b0;
    end
  end

  always_ff @(posedge VGA_CLK) begin
    if (w_write) r_line[w_addr] <= iDATA;
  end

  // Left-hand window column is simply the previous in-range pixel's column.
  always_ff @(posedge VGA_CLK) begin
    if (!RESET_N) begin
      r_s1_vld <= 1'b0;
      r_s1_ul  <= '0;
      r_s1_up  <= '0;
      r_s1_l   <= '0;
      r_s1_c   <= '0;
      r_s1_xp  <= 1'b0;
      r_s1_yp  <= 1'b0;
    end else begin
      r_s1_vld <= w_write & (w_x != '0) & w_y_nz;
      if (w_write) begin
        r_s1_ul <= r_s1_up;
        r_s1_l  <= r_s1_c;
        r_s1_up <= r_line[w_addr];
        r_s1_c  <= iDATA;
        r_s1_xp <= ~w_x[0];
        r_s1_yp <= ~w_y_odd;
      end
    end
  end

  logic [1:0]        w_sel;
  logic [DATA_W-1:0] w_win [4];
  logic [DATA_W-1:0] w_r, w_g, w_b, w_gray;
  logic [DATA_W:0]   w_gsum;
  logic [LW-1:0]     w_luma;

  // Window index {dy,dx}; red sits where the top-left parity XOR the pattern code is zero.
  always_comb begin
    w_win[0] = r_s1_ul;
    w_win[1] = r_s1_up;
    w_win[2] = r_s1_l;
    w_win[3] = r_s1_c;
    w_sel    = {r_s1_yp ^ r_pat[1], r_s1_xp ^ r_pat[0]};
    w_r      = w_win[w_sel];
    w_b      = w_win[~w_sel];
    w_gsum   = {1'b0, w_win[w_sel ^ 2'd1]} + {1'b0, w_win[w_sel ^ 2'd2]};
    w_g      = DATA_W'(w_gsum >> 1);
    w_luma   = LW'(w_r) * LW'(77) + LW'(w_g) * LW'(150) + LW'(w_b) * LW'(29);
    w_gray   = DATA_W'(w_luma >> 8);
  end

  always_ff @(posedge VGA_CLK) begin
    if (!RESET_N) begin
      oDVAL  <= 1'b0;
      oRed   <= '0;
      oGreen <= '0;
      oBlue  <= '0;
      oGray  <= '0;
    end else begin
      oDVAL <= r_s1_vld;
      if (r_s1_vld) begin
        oGray  <= OUT_W'(w_gray >> SH);
        oRed   <= r_mode ? OUT_W'(w_gray >> SH) : OUT_W'(w_r >> SH);
        oGreen <= r_mode ? OUT_W'(w_gray >> SH) : OUT_W'(w_g >> SH);
        oBlue  <= r_mode ? OUT_W'(w_gray >> SH) : OUT_W'(w_b >> SH);
      end
    end
  end
endmodule

// File: tb/tb_raw2rgb_bayer_p.sv
// tb/tb_raw2rgb_bayer_p.sv - bench for raw2rgb_bayer_p against a frame-level demosaic model
module tb_raw2rgb_bayer_p;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, fval, lval, dval, mode;
  logic [9:0] data;
  logic [1:0] pat;
  logic [7:0] o_r [2], o_g [2], o_b [2], o_y [2];
  logic       o_dv [2], o_ovf [2];

  raw2rgb_bayer_p #(.DATA_W(10), .OUT_W(8), .LINE_MAX(1024), .ADDR_W(10)) u_big (
    .VGA_CLK(clk), .RESET_N(rst_n), .iFVAL(fval), .iLVAL(lval), .iDVAL(dval), .iDATA(data),
    .iPATTERN(pat), .iMODE(mode), .oRed(o_r[0]), .oGreen(o_g[0]), .oBlue(o_b[0]),
    .oGray(o_y[0]), .oDVAL(o_dv[0]), .oOVF(o_ovf[0]));

  raw2rgb_bayer_p #(.DATA_W(10), .OUT_W(8), .LINE_MAX(8), .ADDR_W(3)) u_small (
    .VGA_CLK(clk), .RESET_N(rst_n), .iFVAL(fval), .iLVAL(lval), .iDVAL(dval), .iDATA(data),
    .iPATTERN(pat), .iMODE(mode), .oRed(o_r[1]), .oGreen(o_g[1]), .oBlue(o_b[1]),
    .oGray(o_y[1]), .oDVAL(o_dv[1]), .oOVF(o_ovf[1]));

  typedef struct {
    logic [7:0] r, g, b, y;
    int         cyc;
  } exp_t;

  exp_t       q0 [$];
  exp_t       q1 [$];
  int         tests = 0, fails = 0, cyc = 0;
  int         lm [2] = '{1024, 8};
  logic [7:0] last_r [2], last_g [2], last_b [2], last_y [2];
  logic       exp_ovf [2], ovf_nxt [2];
  int         npulse [2];
  logic [9:0] pix [16][16];
  int         mx, my;
  logic [1:0] mpat, drv_pat;
  logic       mmode, drv_mode, mact, rst_evt;

  always @(posedge clk) cyc <= cyc + 1;

  // 0 = red, 1 = green, 2 = blue for the sensor site at (y, x)
  function automatic int colour(input logic [1:0] p, input int y, input int x);
    int t;
    t = (y % 2) * 2 + (x % 2);
    if (t == int'(p)) return 0;
    if (t == 3 - int'(p)) return 2;
    return 1;
  endfunction

  function automatic exp_t model(input int y, input int x);
    exp_t e;
    int r, g, b, c, v, gy;
    r = 0; g = 0; b = 0;
    for (int dy = 0; dy < 2; dy++)
      for (int dx = 0; dx < 2; dx++) begin
        v = int'(pix[y-1+dy][x-1+dx]);
        c = colour(mpat, y - 1 + dy, x - 1 + dx);
        if (c == 0) r = v;
        else if (c == 2) b = v;
        else g = g + v;
      end
    g  = g / 2;
    gy = (77 * r + 150 * g + 29 * b) / 256;
    e.y = 8'(gy / 4);
    e.r = mmode ? 8'(gy / 4) : 8'(r / 4);
    e.g = mmode ? 8'(gy / 4) : 8'(g / 4);
    e.b = mmode ? 8'(gy / 4) : 8'(b / 4);
    e.cyc = 0;
    return e;
  endfunction

  task automatic cyc_step();
    exp_t e;
    int   qs;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (o_ovf[d] !== exp_ovf[d]) begin
        fails++;
        $display("FAIL ovf dut%0d cyc=%0d: got %b want %b", d, cyc, o_ovf[d], exp_ovf[d]);
      end
      if (o_dv[d] === 1'b1) begin
        npulse[d]++;
        qs = (d == 0) ? q0.size() : q1.size();
        tests++;
        if (qs == 0) begin
          fails++;
          $display("FAIL extra_dval dut%0d cyc=%0d: got oDVAL=1 want 0", d, cyc);
        end else begin
          if (d == 0) e = q0.pop_front();
          else e = q1.pop_front();
          if (o_r[d] !== e.r || o_g[d] !== e.g || o_b[d] !== e.b || o_y[d] !== e.y || cyc != e.cyc) begin
            fails++;
            $display("FAIL pixel dut%0d: got r=%0d g=%0d b=%0d y=%0d cyc=%0d want r=%0d g=%0d b=%0d y=%0d cyc=%0d",
                     d, o_r[d], o_g[d], o_b[d], o_y[d], cyc, e.r, e.g, e.b, e.y, e.cyc);
          end
          last_r[d] = e.r; last_g[d] = e.g; last_b[d] = e.b; last_y[d] = e.y;
        end
      end else begin
        tests++;
        if (o_dv[d] !== 1'b0 || o_r[d] !== last_r[d] || o_g[d] !== last_g[d] ||
            o_b[d] !== last_b[d] || o_y[d] !== last_y[d]) begin
          fails++;
          $display("FAIL hold dut%0d cyc=%0d: got dv=%b r=%0d g=%0d b=%0d y=%0d want dv=0 r=%0d g=%0d b=%0d y=%0d",
                   d, cyc, o_dv[d], o_r[d], o_g[d], o_b[d], o_y[d], last_r[d], last_g[d], last_b[d], last_y[d]);
        end
      end
    end
    if (rst_evt) begin
      q0.delete();
      q1.delete();
      for (int d = 0; d < 2; d++) begin
        last_r[d] = 8'd0; last_g[d] = 8'd0; last_b[d] = 8'd0; last_y[d] = 8'd0;
        ovf_nxt[d] = 1'b0;
      end
      rst_evt = 1'b0;
    end
    for (int d = 0; d < 2; d++) exp_ovf[d] = ovf_nxt[d];
    @(posedge clk);
    #1;
  endtask

  task automatic px(input bit v);
    exp_t e;
    fval = 1'b1; lval = 1'b1; dval = v; pat = drv_pat; mode = drv_mode;
    data = (v && mact) ? pix[my][mx] : 10'($urandom_range(0, 1023));
    if (v && mact) begin
      for (int d = 0; d < 2; d++) begin
        if (mx >= lm[d]) ovf_nxt[d] = 1'b1;
        else if (mx >= 1 && my >= 1) begin
          e = model(my, mx);
          e.cyc = cyc + 2;
          if (d == 0) q0.push_back(e);
          else q1.push_back(e);
        end
      end
      mx++;
    end
    cyc_step();
  endtask

  task automatic frame_start(input logic [1:0] p, input logic m, input bit combo);
    drv_pat = p; drv_mode = m; mpat = p; mmode = m; mact = 1'b1; mx = 0; my = 0;
    ovf_nxt[0] = 1'b0; ovf_nxt[1] = 1'b0;
    if (combo) px(1'b1);
    else begin
      fval = 1'b1; lval = 1'b0; dval = 1'b0; pat = p; mode = m;
      cyc_step();
    end
  endtask

  task automatic line_end();
    fval = 1'b1; lval = 1'b0; dval = 1'b0;
    cyc_step();
    my++;
    mx = 0;
  endtask

  task automatic frame_end();
    fval = 1'b0; lval = 1'b0; dval = 1'b0;
    repeat (4) cyc_step();
    mact = 1'b0;
    tests++;
    if (q0.size() != 0 || q1.size() != 0) begin
      fails++;
      $display("FAIL missing_outputs: got %0d/%0d pending want 0/0", q0.size(), q1.size());
    end
  endtask

  task automatic run_frame(input int w, input int h, input logic [1:0] p, input logic m,
                           input bit combo, input int stall, input int mid_pat);
    frame_start(p, m, combo);
    if (mid_pat >= 0) drv_pat = 2'(mid_pat);
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        if (!(combo && y == 0 && x == 0)) begin
          if (stall == 1 && $urandom_range(0, 1) == 1) px(1'b0);
          px(1'b1);
          if (stall == 2) px(1'b0);
        end
      end
      line_end();
    end
    frame_end();
  endtask

  task automatic fill_rand(input int w, input int h);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) pix[y][x] = 10'($urandom_range(0, 1023));
  endtask

  task automatic load_spec_frame();
    pix[0][0] = 10'd100; pix[0][1] = 10'd200; pix[0][2] = 10'd104; pix[0][3] = 10'd204;
    pix[1][0] = 10'd300; pix[1][1] = 10'd400; pix[1][2] = 10'd304; pix[1][3] = 10'd404;
  endtask

  task automatic test_reset();
    fval = 1'b1; lval = 1'b1; dval = 1'b1; data = 10'($urandom_range(0, 1023));
    repeat (3) cyc_step();
    tests++;
    if (o_dv[0] !== 1'b0 || o_r[0] !== 8'd0 || o_g[0] !== 8'd0 || o_b[0] !== 8'd0 ||
        o_y[0] !== 8'd0 || o_ovf[0] !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: got dv=%b r=%0d g=%0d b=%0d y=%0d ovf=%b want all 0",
               o_dv[0], o_r[0], o_g[0], o_b[0], o_y[0], o_ovf[0]);
    end
    rst_n = 1'b1;
    mact = 1'b0;
    repeat (4) px(1'b1);
    fval = 1'b0; lval = 1'b0; dval = 1'b0;
    cyc_step();
  endtask

  task automatic test_rggb();
    load_spec_frame();
    npulse[0] = 0; npulse[1] = 0;
    run_frame(4, 2, 2'd0, 1'b0, 1'b0, 0, -1);
    tests++;
    if (npulse[0] != 3 || npulse[1] != 3) begin
      fails++;
      $display("FAIL rggb_pulses: got %0d/%0d want 3/3", npulse[0], npulse[1]);
    end
    tests++;
    if (o_r[0] !== 8'd26 || o_g[0] !== 8'd63 || o_b[0] !== 8'd101) begin
      fails++;
      $display("FAIL rggb_last: got r=%0d g=%0d b=%0d want r=26 g=63 b=101", o_r[0], o_g[0], o_b[0]);
    end
  endtask

  task automatic test_bggr_pattern_change();
    load_spec_frame();
    run_frame(4, 2, 2'd3, 1'b0, 1'b0, 0, 0);
    tests++;
    if (o_r[0] !== 8'd101 || o_g[0] !== 8'd63 || o_b[0] !== 8'd26) begin
      fails++;
      $display("FAIL bggr_last: got r=%0d g=%0d b=%0d want r=101 g=63 b=26", o_r[0], o_g[0], o_b[0]);
    end
    fill_rand(5, 3);
    run_frame(5, 3, 2'd0, 1'b0, 1'b0, 0, -1);
  endtask

  task automatic test_gray();
    pix[0][0] = 10'd1000; pix[0][1] = 10'd0; pix[1][0] = 10'd0; pix[1][1] = 10'd0;
    run_frame(2, 2, 2'd0, 1'b1, 1'b0, 0, -1);
    tests++;
    if (o_y[0] !== 8'd75 || o_r[0] !== 8'd75 || o_g[0] !== 8'd75 || o_b[0] !== 8'd75) begin
      fails++;
      $display("FAIL gray_r1000: got y=%0d r=%0d g=%0d b=%0d want 75", o_y[0], o_r[0], o_g[0], o_b[0]);
    end
    fill_rand(5, 3);
    run_frame(5, 3, 2'($urandom_range(0, 3)), 1'b1, 1'b0, 0, -1);
  endtask

  task automatic test_stall();
    fill_rand(6, 3);
    run_frame(6, 3, 2'd1, 1'b0, 1'b0, 2, -1);
    run_frame(6, 3, 2'd1, 1'b0, 1'b0, 0, -1);
    run_frame(6, 3, 2'd2, 1'b0, 1'b0, 1, -1);
  endtask

  task automatic test_overflow();
    fill_rand(10, 3);
    run_frame(10, 3, 2'd0, 1'b0, 1'b0, 0, -1);
    tests++;
    if (o_ovf[1] !== 1'b1 || o_ovf[0] !== 1'b0) begin
      fails++;
      $display("FAIL ovf_sticky: got small=%b big=%b want small=1 big=0", o_ovf[1], o_ovf[0]);
    end
    fill_rand(4, 2);
    run_frame(4, 2, 2'd3, 1'b0, 1'b0, 0, -1);
    tests++;
    if (o_ovf[1] !== 1'b0) begin
      fails++;
      $display("FAIL ovf_clear: got %b want 0", o_ovf[1]);
    end
  endtask

  task automatic test_combo_start();
    fill_rand(5, 3);
    run_frame(5, 3, 2'd2, 1'b0, 1'b1, 0, -1);
  endtask

  task automatic test_reset_mid();
    fill_rand(6, 3);
    frame_start(2'd1, 1'b0, 1'b0);
    for (int x = 0; x < 6; x++) px(1'b1);
    line_end();
    for (int x = 0; x < 3; x++) px(1'b1);
    rst_n = 1'b0; fval = 1'b1; lval = 1'b1; dval = 1'b1;
    data = 10'($urandom_range(0, 1023));
    rst_evt = 1'b1; mact = 1'b0;
    cyc_step();
    rst_n = 1'b1;
    repeat (5) px(1'b1);
    tests++;
    if (o_dv[0] !== 1'b0 || o_r[0] !== 8'd0 || o_y[0] !== 8'd0) begin
      fails++;
      $display("FAIL reset_mid: got dv=%b r=%0d y=%0d want 0", o_dv[0], o_r[0], o_y[0]);
    end
    frame_end();
    fill_rand(4, 3);
    run_frame(4, 3, 2'd1, 1'b0, 1'b0, 0, -1);
  endtask

  task automatic test_random();
    int w, h;
    for (int n = 0; n < 6; n++) begin
      w = $urandom_range(2, 12);
      h = $urandom_range(2, 4);
      fill_rand(w, h);
      run_frame(w, h, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(0, 2), -1);
    end
  endtask

  initial begin
    rst_n = 1'b0; fval = 1'b0; lval = 1'b0; dval = 1'b0; data = 10'd0; pat = 2'd0; mode = 1'b0;
    drv_pat = 2'd0; drv_mode = 1'b0; mpat = 2'd0; mmode = 1'b0; mact = 1'b0; rst_evt = 1'b0;
    mx = 0; my = 0;
    for (int d = 0; d < 2; d++) begin
      last_r[d] = 8'd0; last_g[d] = 8'd0; last_b[d] = 8'd0; last_y[d] = 8'd0;
      exp_ovf[d] = 1'b0; ovf_nxt[d] = 1'b0; npulse[d] = 0;
    end
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) pix[y][x] = 10'd0;
    @(posedge clk);
    #1;
    test_reset();
    test_rggb();
    test_bggr_pattern_change();
    test_gray();
    test_stall();
    test_overflow();
    test_combo_start();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
